// File: rtl/proc_pkg.sv
// Shared types and helpers for the multi-cycle processor core.
package proc_pkg;

  localparam int unsigned SEXT_W = 64;

  typedef enum logic [2:0] {
    OP_DISP = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SLL  = 3'b110,
    OP_MOVI = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IMM  = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  // Sign-extend the low w bits of v; callers truncate to their datapath width.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int unsigned w);
    logic [SEXT_W-1:0] m;
    m = {SEXT_W{1'b1}} << w;
    return v[6'(w - 1)] ? (v | m) : (v & ~m);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU; results wrap to DATA_W bits.
module proc_alu
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_SRL:  result = a >> sh;
      OP_SLL:  result = a << sh;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/register_n.sv
// Generic enabled register with asynchronous active-low clear.
module register_n #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/proc_core_mc.sv
// Multi-cycle 8-opcode core: register bank, A/G/H registers and run/immediate handshake.
module proc_core_mc
  import proc_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned SEL_W  = 3,
  localparam int unsigned IR_W   = 3 + 2 * SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [IR_W-1:0]   din,
  output logic              busy,
  output logic              imm_req,
  output logic              done,
  output logic [DATA_W-1:0] disp
);

  localparam int unsigned NREGS = 2 ** SEL_W;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              busy_d, imm_req_d, done_d;
  logic              r_we, a_en, g_en, h_en;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_q [NREGS];
  logic [DATA_W-1:0] a_q, g_q, h_q, alu_b, alu_res;
  opcode_t           op, op_in, alu_op;
  logic [SEL_W-1:0]  rx, ry;

  assign op    = opcode_t'(ir_q[IR_W-1 -: 3]);
  assign op_in = opcode_t'(din[IR_W-1 -: 3]);
  assign rx    = ir_q[2*SEL_W-1 -: SEL_W];
  assign ry    = ir_q[SEL_W-1:0];

  // ADDI reuses the adder with the captured immediate as second operand.
  assign alu_op = (op == OP_ADDI) ? OP_ADD : op;
  assign alu_b  = (op == OP_ADDI) ? imm_q : r_q[ry];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      imm_q     <= '0;
      busy      <= 1'b0;
      imm_req   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      busy      <= busy_d;
      imm_req   <= imm_req_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    r_we    = 1'b0;
    r_wdata = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    h_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = din;
          state_d = (op_in == OP_ADDI || op_in == OP_MOVI) ? S_IMM : S_T1;
        end
      end
      S_IMM: begin
        if (run) begin
          imm_d   = DATA_W'(sext(SEXT_W'(din), IR_W));
          state_d = S_T1;
        end
      end
      S_T1: begin
        case (op)
          OP_DISP: begin
            h_en    = 1'b1;
            state_d = S_IDLE;
          end
          OP_MOVI: begin
            r_we    = 1'b1;
            r_wdata = imm_q;
            state_d = S_IDLE;
          end
          default: begin
            a_en    = 1'b1;
            state_d = S_T2;
          end
        endcase
      end
      S_T2: begin
        g_en    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        r_we    = 1'b1;
        r_wdata = g_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d    = (state_d != S_IDLE);
    imm_req_d = (state_d == S_IMM);
    done_d    = (state_d == S_T3) ||
                ((state_d == S_T1) && (opcode_t'(ir_d[IR_W-1 -: 3]) inside {OP_DISP, OP_MOVI}));
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    register_n #(.W(DATA_W)) u_r (
      .clk (clk),
      .rst (rst),
      .en  (r_we && (rx == SEL_W'(i))),
      .d   (r_wdata),
      .q   (r_q[i])
    );
  end

  register_n #(.W(DATA_W)) u_a (.clk(clk), .rst(rst), .en(a_en), .d(r_q[rx]), .q(a_q));
  register_n #(.W(DATA_W)) u_g (.clk(clk), .rst(rst), .en(g_en), .d(alu_res), .q(g_q));
  register_n #(.W(DATA_W)) u_h (.clk(clk), .rst(rst), .en(h_en), .d(r_q[rx]), .q(h_q));

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_res)
  );

  assign disp = h_q;

endmodule

// File: tb/tb_proc_core_mc.sv
// Scoreboard bench for proc_core_mc: registers are observed through DISP.
module tb_proc_core_mc;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IR_W   = 9;

  localparam logic [2:0] C_DISP = 3'b000;
  localparam logic [2:0] C_ADD  = 3'b001;
  localparam logic [2:0] C_ADDI = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_MUL  = 3'b100;
  localparam logic [2:0] C_SRL  = 3'b101;
  localparam logic [2:0] C_SLL  = 3'b110;
  localparam logic [2:0] C_MOVI = 3'b111;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic [IR_W-1:0]   din = '0;
  logic              busy, imm_req, done;
  logic [DATA_W-1:0] disp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] disp_q [$];

  proc_core_mc #(.DATA_W(16), .SEL_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .din     (din),
    .busy    (busy),
    .imm_req (imm_req),
    .done    (done),
    .disp    (disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one instruction; exp_lat is counted from the last capture edge (IR or immediate).
  task automatic exec(input logic [2:0] op, input int rx, input int ry, input logic [8:0] imm,
                      input int hold, input bit poke, input int exp_lat, input string tag);
    int k;
    bit seen;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    run = 1'b1;
    din = {op, 3'(rx), 3'(ry)};
    @(posedge clk);
    @(negedge clk);
    if (op == C_ADDI || op == C_MOVI) begin
      run = 1'b0;
      chk({tag, "/imm_req"}, 32'(imm_req), 32'd1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "/wait"}, 32'({busy, imm_req, done}), 32'b110);
      end
      din = imm;
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    run  = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 20) begin
      if (poke && k == 2) run = 1'b1;
      if (poke && k == 3) run = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "/lat"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (op == C_DISP) begin
      @(posedge clk);
      #1;
      chk({tag, "/sb_depth"}, 32'(disp_q.size()), 32'd1);
      if (disp_q.size() > 0) begin
        e = disp_q.pop_front();
        chk({tag, "/disp"}, 32'(disp), 32'(e));
      end
    end
    @(negedge clk);
    chk({tag, "/idle"}, 32'({busy, done}), 32'd0);
  endtask

  task automatic movi(input int rx, input logic [8:0] imm, input string tag);
    exec(C_MOVI, rx, 0, imm, 0, 1'b0, 1, tag);
  endtask

  task automatic alu(input logic [2:0] op, input int rx, input int ry, input string tag);
    exec(op, rx, ry, 9'h000, 0, 1'b0, 3, tag);
  endtask

  task automatic addi(input int rx, input logic [8:0] imm, input string tag);
    exec(C_ADDI, rx, 0, imm, 0, 1'b0, 3, tag);
  endtask

  task automatic show(input int rx, input logic [DATA_W-1:0] exp, input string tag);
    disp_q.push_back(exp);
    exec(C_DISP, rx, 0, 9'h000, 0, 1'b0, 1, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/status", 32'({busy, imm_req, done}), 32'd0);
    chk("reset/disp", 32'(disp), 32'd0);
    rst = 1'b1;

    movi(1, 9'h1FF, "movi_r1");
    show(1, 16'hFFFF, "disp_r1");

    movi(2, 9'h005, "movi_r2");
    movi(3, 9'h007, "movi_r3");
    alu(C_ADD, 2, 3, "add");
    show(2, 16'h000C, "disp_add");
    alu(C_SUB, 3, 2, "sub");
    show(3, 16'hFFFB, "disp_sub");
    alu(C_ADD, 2, 2, "add_alias");
    show(2, 16'h0018, "disp_alias");

    movi(4, 9'h001, "movi_r4");
    movi(0, 9'h008, "movi_r0_8");
    alu(C_SLL, 4, 0, "sll8_r4");
    movi(5, 9'h001, "movi_r5");
    alu(C_SLL, 5, 0, "sll8_r5");
    addi(5, 9'h001, "addi_r5");
    show(5, 16'h0101, "disp_r5");
    alu(C_MUL, 4, 5, "mul");
    show(4, 16'h0100, "disp_mul");
    addi(4, 9'h1FF, "addi_neg");
    show(4, 16'h00FF, "disp_addi");

    movi(6, 9'h001, "movi_r6");
    movi(0, 9'h00F, "movi_r0_15");
    alu(C_SLL, 6, 0, "sll15_r6");
    addi(6, 9'h001, "addi_r6");
    show(6, 16'h8001, "disp_r6");
    movi(7, 9'h011, "movi_r7");
    alu(C_SRL, 6, 7, "srl");
    show(6, 16'h4000, "disp_srl");
    movi(6, 9'h001, "movi_r6b");
    alu(C_SLL, 6, 0, "sll15_r6b");
    addi(6, 9'h001, "addi_r6b");
    alu(C_SLL, 6, 7, "sll");
    show(6, 16'h0002, "disp_sll");
    movi(0, 9'h010, "movi_r0_16");
    alu(C_SRL, 7, 0, "srl_zero");
    show(7, 16'h0011, "disp_srl0");

    exec(C_MOVI, 3, 0, 9'h003, 10, 1'b0, 1, "hs_movi");
    show(3, 16'h0003, "disp_hs");
    exec(C_ADD, 3, 3, 9'h000, 0, 1'b1, 3, "poke_add");
    show(3, 16'h0006, "disp_poke");

    @(negedge clk);
    run = 1'b1;
    din = {C_ADD, 3'd2, 3'd3};
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("rst_mid/pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid/status", 32'({busy, imm_req, done}), 32'd0);
    chk("rst_mid/disp", 32'(disp), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid/hold", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 8; r++) show(r, 16'h0000, $sformatf("rst_r%0d", r));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
